// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data-memory sequencer states and defaults.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int          DMEM_TIMEOUT_DEFAULT = 16;
  localparam logic [31:0] DMEM_ERR_DATA        = 32'h0000_0000;

endpackage

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: request one cycle after the load/store is seen, result one cycle after mem_ready.
// Stalls the pipeline while waiting on mem_ready; a wait-cycle counter aborts after TIMEOUT cycles with a sticky bus_err.
module dmem_access_ctrl
  import mips_pkg::*;
#(
  parameter int          TIMEOUT  = DMEM_TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_DATA = DMEM_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        bus_err
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  dmem_state_t   state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      read_data <= 32'h0;
      bus_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memread || memwrite) begin
            mem_req   <= 1'b1;
            mem_we    <= memwrite;  // store wins when both controls are high
            mem_addr  <= addr_in;
            mem_wdata <= wdata_in;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) read_data <= mem_rdata;
            state <= DONE;
          end else if (cnt == LAST) begin
            // Counter holds at LAST on abort rather than wrapping
            mem_req <= 1'b0;
            if (!mem_we) read_data <= ERR_DATA;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // The finished instruction is still in EX/MEM here, so do not re-sample it
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = ((state == IDLE) && (memread || memwrite)) || (state == BUSY);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed per-cycle vector table plus a hand-written mid-access reset sequence for dmem_access_ctrl.
module tb_dmem_access_ctrl;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread, memwrite, mem_ready;
  logic [31:0] addr_in, wdata_in, mem_rdata;
  logic        mem_req, mem_we, stall, bus_err;
  logic [31:0] mem_addr, mem_wdata, read_data;

  int tests = 0;
  int fails = 0;

  dmem_access_ctrl #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .memread(memread), .memwrite(memwrite),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .read_data(read_data), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic rdy, logic [31:0] rdata,
                              logic e_stall, logic e_req, logic e_we,
                              logic [31:0] e_addr, logic [31:0] e_wdata,
                              logic [31:0] e_rd, logic e_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdy = rdy; v.rdata = rdata;
    v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rd = e_rd; v.e_err = e_err;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, int cyc, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(logic rd, logic wr, logic [31:0] a, logic [31:0] w, logic rdy, logic [31:0] rdt);
    memread = rd; memwrite = wr; addr_in = a; wdata_in = w; mem_ready = rdy; mem_rdata = rdt;
  endtask

  initial begin
    // Load zero-wait, with stray mem_ready in DONE/IDLE that must be ignored
    add(1,0,32'h10,0,0,0,                      1,0,0,0,0,32'h0,0);
    add(1,0,32'h10,0,1,32'h1234_5678,          1,1,0,32'h10,0,32'h0,0);
    add(1,0,32'h10,0,1,32'hFFFF_FFFF,          0,0,0,0,0,32'h1234_5678,0);
    add(0,0,0,0,1,32'hFFFF_FFFF,               0,0,0,0,0,32'h1234_5678,0);
    // Store, three wait cycles
    add(0,1,32'h20,32'hCAFE_F00D,0,0,          1,0,0,0,0,32'h1234_5678,0);
    add(0,1,32'h20,32'hCAFE_F00D,0,0,          1,1,1,32'h20,32'hCAFE_F00D,32'h1234_5678,0);
    add(0,1,32'h20,32'hCAFE_F00D,0,0,          1,1,1,32'h20,32'hCAFE_F00D,32'h1234_5678,0);
    add(0,1,32'h20,32'hCAFE_F00D,0,0,          1,1,1,32'h20,32'hCAFE_F00D,32'h1234_5678,0);
    add(0,1,32'h20,32'hCAFE_F00D,1,32'h1357_2468,1,1,1,32'h20,32'hCAFE_F00D,32'h1234_5678,0);
    add(0,1,32'h20,32'hCAFE_F00D,0,0,          0,0,0,0,0,32'h1234_5678,0);
    add(0,0,0,0,0,0,                           0,0,0,0,0,32'h1234_5678,0);
    // Both controls high: performed as a write
    add(1,1,32'h30,32'h55AA_55AA,0,0,          1,0,0,0,0,32'h1234_5678,0);
    add(1,1,32'h30,32'h55AA_55AA,1,32'h9999_9999,1,1,1,32'h30,32'h55AA_55AA,32'h1234_5678,0);
    add(1,1,32'h30,32'h55AA_55AA,0,0,          0,0,0,0,0,32'h1234_5678,0);
    add(0,0,0,0,1,32'hEEEE_EEEE,               0,0,0,0,0,32'h1234_5678,0);
    // Back-to-back load then store
    add(1,0,32'h44,0,0,0,                      1,0,0,0,0,32'h1234_5678,0);
    add(1,0,32'h44,0,1,32'hA5A5_0001,          1,1,0,32'h44,0,32'h1234_5678,0);
    add(1,0,32'h44,0,0,0,                      0,0,0,0,0,32'hA5A5_0001,0);
    add(0,1,32'h48,32'h0BAD_F00D,0,0,          1,0,0,0,0,32'hA5A5_0001,0);
    add(0,1,32'h48,32'h0BAD_F00D,1,0,          1,1,1,32'h48,32'h0BAD_F00D,32'hA5A5_0001,0);
    add(0,1,32'h48,32'h0BAD_F00D,0,0,          0,0,0,0,0,32'hA5A5_0001,0);
    add(0,0,0,0,0,0,                           0,0,0,0,0,32'hA5A5_0001,0);
    // Timeout: mem_req for exactly TO cycles, then ERR data and sticky bus_err
    add(1,0,32'h50,0,0,0,                      1,0,0,0,0,32'hA5A5_0001,0);
    for (int i = 0; i < TO; i++)
      add(1,0,32'h50,0,0,0,                    1,1,0,32'h50,0,32'hA5A5_0001,0);
    add(1,0,32'h50,0,0,0,                      0,0,0,0,0,ERR,1);
    add(0,0,0,0,0,0,                           0,0,0,0,0,ERR,1);
    // Good load afterwards keeps bus_err set
    add(1,0,32'h60,0,0,0,                      1,0,0,0,0,ERR,1);
    add(1,0,32'h60,0,1,32'h0000_0077,          1,1,0,32'h60,0,ERR,1);
    add(1,0,32'h60,0,0,0,                      0,0,0,0,0,32'h0000_0077,1);
    add(0,0,0,0,0,0,                           0,0,0,0,0,32'h0000_0077,1);

    // Reset state
    drive(0,0,0,0,0,0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_mem_req", -1, {31'b0, mem_req}, 32'h0);
    chk("reset_mem_we", -1, {31'b0, mem_we}, 32'h0);
    chk("reset_mem_addr", -1, mem_addr, 32'h0);
    chk("reset_mem_wdata", -1, mem_wdata, 32'h0);
    chk("reset_read_data", -1, read_data, 32'h0);
    chk("reset_bus_err", -1, {31'b0, bus_err}, 32'h0);
    chk("reset_stall", -1, {31'b0, stall}, 32'h0);
    rst = 1'b0;

    for (int c = 0; c < vq.size(); c++) begin
      @(negedge clk);
      drive(vq[c].rd, vq[c].wr, vq[c].addr, vq[c].wdata, vq[c].rdy, vq[c].rdata);
      #1;
      chk("stall", c, {31'b0, stall}, {31'b0, vq[c].e_stall});
      chk("mem_req", c, {31'b0, mem_req}, {31'b0, vq[c].e_req});
      chk("read_data", c, read_data, vq[c].e_rd);
      chk("bus_err", c, {31'b0, bus_err}, {31'b0, vq[c].e_err});
      if (vq[c].e_req) begin
        chk("mem_we", c, {31'b0, mem_we}, {31'b0, vq[c].e_we});
        chk("mem_addr", c, mem_addr, vq[c].e_addr);
        chk("mem_wdata", c, mem_wdata, vq[c].e_wdata);
      end
    end

    // Asynchronous reset in the middle of a BUSY access (bus_err is set beforehand)
    @(negedge clk);
    drive(1,0,32'h40,0,0,0);
    @(negedge clk);
    #1;
    chk("midrst_busy_req", 100, {31'b0, mem_req}, 32'h1);
    chk("midrst_busy_addr", 100, mem_addr, 32'h40);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", 101, {31'b0, mem_req}, 32'h0);
    chk("midrst_mem_addr", 101, mem_addr, 32'h0);
    chk("midrst_read_data", 101, read_data, 32'h0);
    chk("midrst_bus_err", 101, {31'b0, bus_err}, 32'h0);
    chk("midrst_stall_idle_req", 101, {31'b0, stall}, 32'h1);
    memread = 1'b0;
    #1;
    chk("midrst_stall_clear", 101, {31'b0, stall}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Normal load after reset
    drive(1,0,32'h70,0,0,0);
    @(negedge clk);
    drive(1,0,32'h70,0,1,32'h0F0F_0F0F);
    #1;
    chk("postrst_req", 102, {31'b0, mem_req}, 32'h1);
    @(negedge clk);
    drive(1,0,32'h70,0,0,0);
    #1;
    chk("postrst_read_data", 103, read_data, 32'h0F0F_0F0F);
    chk("postrst_stall", 103, {31'b0, stall}, 32'h0);
    chk("postrst_bus_err", 103, {31'b0, bus_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer for data-memory accesses issued from the MEM stage of the five-stage MIPS pipeline. Converts the EX/MEM memread/memwrite controls into a registered request/ready handshake toward a variable-latency data memory. It raises a pipeline stall until the access completes and presents the captured read data to the MEM/WB latch. A wait-cycle counter enforces a timeout and reports a sticky bus error.

## Interface

Parameters:
- TIMEOUT, 16: maximum BUSY cycles before abort; legal range 1..255.
- ERR_DATA, 32'h0000_0000: read data returned on timeout.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- memread  input  1  load in MEM stage (EX/MEM control).
- memwrite  input  1  store in MEM stage (EX/MEM control).
- addr_in  input  32  ALU result / effective address.
- wdata_in  input  32  store data.
- mem_req  output  1  registered request to data memory.
- mem_we  output  1  registered write enable; valid while mem_req=1.
- mem_addr  output  32  registered address; stable while mem_req=1.
- mem_wdata  output  32  registered store data; stable while mem_req=1.
- mem_rdata  input  32  memory read data; valid when mem_ready=1.
- mem_ready  input  1  access complete; sampled only in BUSY.
- stall  output  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM.
- read_data  output  32  registered load result, feeds MEM/WB read_data_in.
- bus_err  output  1  sticky timeout flag.

## Operation

- States: IDLE, BUSY, DONE.
- IDLE:
  - If memread|memwrite, latch addr_in/wdata_in and set mem_req=1 next edge.
  - mem_we=memwrite. If both controls are high, the access is a write.
  - Clear the wait counter and go to BUSY.
- BUSY:
  - Hold mem_req/mem_we/mem_addr/mem_wdata constant; counter increments each cycle.
  - On mem_ready=1: for a read, read_data<=mem_rdata; for a write, read_data is unchanged. Drop mem_req and go to DONE.
  - If the counter reaches TIMEOUT-1 with no mem_ready: drop mem_req, read_data<=ERR_DATA for reads, set bus_err=1, go to DONE.
- DONE: stall=0 for one cycle so the pipeline latches advance. Return unconditionally to IDLE without re-sampling memread/memwrite, because the same instruction is still present this cycle.
- stall = (IDLE & (memread|memwrite)) | BUSY.
- mem_ready outside BUSY is ignored. bus_err clears only on rst.
- Counter width is $clog2(TIMEOUT+1). The counter never wraps; it saturates at abort.

## Timing

- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read_data=0, bus_err=0, counter=0. stall follows inputs combinationally (0 when no request).
- Reset mid-access: immediate return to IDLE, mem_req drops asynchronously, and any in-flight data is discarded.
- Request seen in cycle 0 (IDLE) → mem_req high from cycle 1.
- mem_ready in cycle k≥1 → DONE in cycle k+1, read_data valid from cycle k+1, stall low in cycle k+1.
- Zero-wait memory (ready in cycle 1) → 2 stall cycles.
- Timeout → mem_req high for exactly TIMEOUT cycles, DONE in cycle TIMEOUT+1.
- Back-to-back memory instructions: the next request is seen in IDLE at cycle k+2. There is a one-cycle bubble per access.

## Structure

- Shared package `mips_pkg`:
  - enum dmem_state_t {IDLE, BUSY, DONE};
  - DMEM_TIMEOUT_DEFAULT;
  - DMEM_ERR_DATA.
- Single flat module, no sub-module; the counter and FSM are inline.

## Test plan

- Reset: assert rst mid-BUSY with addr 0x40 → mem_req=0, state IDLE, read_data=0, bus_err=0 immediately; stall=0 once memread=0.
- Load, zero wait: memread=1, addr_in=0x10, mem_ready in cycle 1, mem_rdata=0x1234_5678 → stall high for cycles 0–1, read_data=0x1234_5678 in cycle 2, stall=0 in cycle 2.
- Store, 3 wait: memwrite=1, addr_in=0x20, wdata_in=0xCAFE_F00D, ready in cycle 4 → mem_we=1 and mem_addr/mem_wdata stable for cycles 1–4, read_data unchanged, DONE in cycle 5.
- Timeout, TIMEOUT=4: memread=1 with no ready → mem_req high for cycles 1–4, read_data=ERR_DATA and bus_err=1 in cycle 5; bus_err still 1 after the next good load.
- Both controls high: memread=memwrite=1 → mem_we=1 (write performed), read_data unchanged.
- Back-to-back: load then store on consecutive instructions → exactly one DONE cycle between the two mem_req pulses, and no duplicate request for the first instruction.
